// File: rtl/if_stage_pkg.sv
// Shared widths, reset/exception vectors and bus layouts for the instruction-fetch stage.
package if_stage_pkg;

    localparam int unsigned FS_TO_DS_BUS_WD = 65;
    localparam int unsigned BR_BUS_WD       = 33;

    localparam logic [31:0] DEF_RESET_PC = 32'hbfc00000;
    localparam logic [31:0] DEF_EX_ENTRY = 32'hbfc00380;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    typedef struct packed {
        logic        ex;
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_t;

    // Redirect priority: exception, then eret, then taken branch, else sequential.
    function automatic logic [31:0] pick_nextpc(input logic        ws_ex,
                                                input logic        ws_eret,
                                                input logic [31:0] epc,
                                                input br_bus_t     br,
                                                input logic [31:0] fs_pc,
                                                input logic [31:0] ex_entry);
        if (ws_ex) begin
            return ex_entry;
        end else if (ws_eret) begin
            return epc;
        end else if (br.taken) begin
            return br.target;
        end
        return fs_pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage signal bundle: decode handshake, writeback redirects and instruction SRAM port.
interface if_stage_if;
    import if_stage_pkg::*;

    logic                       ds_allowin;
    logic [BR_BUS_WD-1:0]       br_bus;
    logic                       ws_ex;
    logic                       ws_eret;
    logic [31:0]                cp0_epc;
    logic                       fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
    logic                       inst_sram_en;
    logic [3:0]                 inst_sram_wen;
    logic [31:0]                inst_sram_addr;
    logic [31:0]                inst_sram_wdata;
    logic [31:0]                inst_sram_rdata;

    modport master (
        input  ds_allowin, br_bus, ws_ex, ws_eret, cp0_epc, inst_sram_rdata,
        output fs_to_ds_valid, fs_to_ds_bus, inst_sram_en, inst_sram_wen,
               inst_sram_addr, inst_sram_wdata
    );

    modport slave (
        output ds_allowin, br_bus, ws_ex, ws_eret, cp0_epc, inst_sram_rdata,
        input  fs_to_ds_valid, fs_to_ds_bus, inst_sram_en, inst_sram_wen,
               inst_sram_addr, inst_sram_wdata
    );

endinterface

// File: rtl/inst_buf_reg.sv
// Holds the fetched instruction while decode stalls, since SRAM data is not kept with en low.
module inst_buf_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        capture,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        valid
);

    logic [31:0] data_q;
    logic        valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            data_q  <= din;
            valid_q <= 1'b1;
        end
    end

    assign dout  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, SRAM request, stall buffer and redirect handling.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EX_ENTRY = DEF_EX_ENTRY
) (
    input  logic       clk,
    input  logic       reset,
    if_stage_if.master fs
);

    br_bus_t     br;
    fs_to_ds_t   fs_out;
    logic        flush;
    logic        fs_allowin;
    logic        fs_valid_q;
    logic [31:0] fs_pc_q;
    logic [31:0] fs_pc_d;
    logic        ex_from_if;
    logic        buf_capture;
    logic        buf_valid;
    logic [31:0] inst_buf;

    always_comb begin
        br         = br_bus_t'(fs.br_bus);
        flush      = fs.ws_ex | fs.ws_eret;
        fs_allowin = !fs_valid_q || fs.ds_allowin || flush;
        fs_pc_d    = pick_nextpc(fs.ws_ex, fs.ws_eret, fs.cp0_epc, br, fs_pc_q, EX_ENTRY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid_q <= 1'b0;
            fs_pc_q    <= RESET_PC - 32'd4;
        end else if (fs_allowin) begin
            fs_valid_q <= 1'b1;
            fs_pc_q    <= fs_pc_d;
        end
    end

    // Capture only on the first stalled cycle; later cycles see stale SRAM data.
    assign buf_capture = fs_valid_q && !fs.ds_allowin && !buf_valid;

    inst_buf_reg u_inst_buf (
        .clk     (clk),
        .reset   (reset),
        .clear   (fs_allowin),
        .capture (buf_capture),
        .din     (fs.inst_sram_rdata),
        .dout    (inst_buf),
        .valid   (buf_valid)
    );

    // Misaligned fetch becomes a nop carrying its PC so decode can report BadVAddr/EPC.
    always_comb begin
        ex_from_if  = fs_valid_q && (fs_pc_q[1:0] != 2'b00);
        fs_out.ex   = ex_from_if;
        fs_out.inst = ex_from_if ? 32'h0 : (buf_valid ? inst_buf : fs.inst_sram_rdata);
        fs_out.pc   = fs_pc_q;
    end

    assign fs.fs_to_ds_bus    = fs_out;
    assign fs.fs_to_ds_valid  = fs_valid_q && !flush;
    assign fs.inst_sram_en    = !reset && fs_allowin;
    assign fs.inst_sram_addr  = fs_pc_d;
    assign fs.inst_sram_wen   = 4'h0;
    assign fs.inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_if_stage.sv
// Randomised scoreboard bench for if_stage with a fetch-stream reference model and SRAM model.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'hbfc00000;
    localparam logic [31:0] EX_VEC = 32'hbfc00380;

    typedef struct packed {
        logic        ex;
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    logic clk;
    logic reset;
    logic chk_en;
    int   n_vec;
    int   n_bad;
    exp_t exp_q[$];
    logic        m_occ;
    logic [31:0] m_pc;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC (RST_PC),
        .EX_ENTRY (EX_VEC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fs    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h24080000;
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] cur);
        if (bus.ws_ex) return EX_VEC;
        if (bus.ws_eret) return bus.cp0_epc;
        if (bus.br_bus[32]) return bus.br_bus[31:0];
        return cur + 32'd4;
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous SRAM: data for the requested address next cycle, garbage when idle.
    initial begin
        bus.inst_sram_rdata = 32'h0;
        forever begin
            @(posedge clk);
            if (bus.inst_sram_en) bus.inst_sram_rdata <= mem_word(bus.inst_sram_addr);
            else bus.inst_sram_rdata <= $urandom;
        end
    end

    // Reference model: tracks which fetch occupies IF and what decode should receive.
    initial begin
        m_occ = 1'b0;
        m_pc  = RST_PC - 32'd4;
        forever begin
            logic [31:0] tgt;
            logic        flush;
            logic        allow;
            exp_t        e;
            @(posedge clk);
            flush = bus.ws_ex | bus.ws_eret;
            tgt   = model_target(m_pc);
            allow = !m_occ || bus.ds_allowin || flush;
            if (reset) begin
                m_occ = 1'b0;
                m_pc  = RST_PC - 32'd4;
                exp_q.delete();
            end else if (allow) begin
                if (m_occ && flush && exp_q.size() > 0) void'(exp_q.pop_back());
                e.ex   = (tgt[1:0] != 2'b00);
                e.inst = e.ex ? 32'h0 : mem_word(tgt);
                e.pc   = tgt;
                exp_q.push_back(e);
                m_occ = 1'b1;
                m_pc  = tgt;
            end
        end
    end

    // Monitor: per-cycle control checks and scoreboard pop on each decode transfer.
    initial begin
        forever begin
            logic        flush;
            logic        allow;
            logic        exp_en;
            logic [31:0] tgt;
            exp_t        e;
            @(negedge clk);
            if (chk_en) begin
                flush  = bus.ws_ex | bus.ws_eret;
                tgt    = model_target(m_pc);
                allow  = !m_occ || bus.ds_allowin || flush;
                exp_en = !reset && allow;
                chk("fs_to_ds_valid", 65'(bus.fs_to_ds_valid), 65'(m_occ && !flush));
                chk("inst_sram_en", 65'(bus.inst_sram_en), 65'(exp_en));
                if (exp_en) chk("inst_sram_addr", 65'(bus.inst_sram_addr), 65'(tgt));
                chk("sram_wen_wdata", {29'h0, bus.inst_sram_wen, bus.inst_sram_wdata}, 65'h0);
                if (bus.fs_to_ds_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("bus_unexpected", bus.fs_to_ds_bus, 65'h0);
                    end else begin
                        e = exp_q[0];
                        chk("fs_to_ds_bus", bus.fs_to_ds_bus, e);
                        if (bus.ds_allowin) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic taken, input logic [31:0] tgt);
        bus.br_bus = {taken, tgt};
    endtask

    initial begin
        logic [64:0] saved;
        n_vec = 0;
        n_bad = 0;
        chk_en = 1'b0;
        reset = 1'b1;
        bus.ds_allowin = 1'b1;
        bus.br_bus = '0;
        bus.ws_ex = 1'b0;
        bus.ws_eret = 1'b0;
        bus.cp0_epc = 32'h0;

        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_state", {63'h0, bus.fs_to_ds_valid, bus.inst_sram_en}, 65'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("release_addr0", {bus.inst_sram_en, bus.inst_sram_addr}, {1'b1, 32'hbfc00000});
        tick();
        chk("release_pc0", {bus.fs_to_ds_valid, bus.fs_to_ds_bus[31:0]}, {1'b1, 32'hbfc00000});
        chk("release_addr1", 65'(bus.inst_sram_addr), 65'(32'hbfc00004));
        tick();
        tick();
        chk("pre_stall_pc", 65'(bus.fs_to_ds_bus[31:0]), 65'(32'hbfc00008));

        bus.ds_allowin = 1'b0;
        #1;
        chk("stall_no_req", 65'(bus.inst_sram_en), 65'h0);
        saved = bus.fs_to_ds_bus;
        repeat (3) tick();
        chk("stall_hold_bus", bus.fs_to_ds_bus, saved);
        chk("stall_inst", 65'(bus.fs_to_ds_bus[63:32]), 65'(mem_word(32'hbfc00008)));
        bus.ds_allowin = 1'b1;
        tick();
        chk("resume_pc", 65'(bus.fs_to_ds_bus[31:0]), 65'(32'hbfc0000c));
        tick();

        set_br(1'b1, 32'hbfc00100);
        tick();
        set_br(1'b0, 32'h0);
        chk("branch_pc", 65'(bus.fs_to_ds_bus[31:0]), 65'(32'hbfc00100));
        tick();

        bus.ws_ex = 1'b1;
        set_br(1'b1, 32'hbfc00200);
        #1;
        chk("ex_flush_valid", 65'(bus.fs_to_ds_valid), 65'h0);
        tick();
        bus.ws_ex = 1'b0;
        set_br(1'b0, 32'h0);
        chk("ex_pc", 65'(bus.fs_to_ds_bus[31:0]), 65'(32'hbfc00380));
        tick();

        bus.ws_eret = 1'b1;
        bus.cp0_epc = 32'hbfc00040;
        tick();
        bus.ws_eret = 1'b0;
        chk("eret_pc", 65'(bus.fs_to_ds_bus[31:0]), 65'(32'hbfc00040));

        set_br(1'b1, 32'hbfc00102);
        tick();
        set_br(1'b0, 32'h0);
        chk("misaligned_bus", bus.fs_to_ds_bus, {1'b1, 32'h0, 32'hbfc00102});
        tick();

        set_br(1'b1, 32'hfffffff8);
        tick();
        set_br(1'b0, 32'h0);
        tick();
        tick();
        chk("wrap_pc", 65'(bus.fs_to_ds_bus[31:0]), 65'h0);

        bus.ds_allowin = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_state", {63'h0, bus.fs_to_ds_valid, bus.inst_sram_en}, 65'h0);
        reset = 1'b0;
        bus.ds_allowin = 1'b1;
        #1;
        chk("midrst_restart", {bus.inst_sram_en, bus.inst_sram_addr}, {1'b1, 32'hbfc00000});
        tick();
        chk("midrst_pc", 65'(bus.fs_to_ds_bus[31:0]), 65'(32'hbfc00000));

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            reset          = ($urandom_range(0, 99) < 2);
            bus.ds_allowin = ($urandom_range(0, 99) < 70);
            bus.ws_ex      = ($urandom_range(0, 99) < 4);
            bus.ws_eret    = ($urandom_range(0, 99) < 4);
            t = RST_PC + ($urandom_range(0, 1023) << 2);
            if ($urandom_range(0, 7) == 0) t = t | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) t = 32'hfffffff8;
            set_br($urandom_range(0, 99) < 15, t);
            bus.cp0_epc = RST_PC + ($urandom_range(0, 255) << 2)
                          + (($urandom_range(0, 9) == 0) ? 32'd2 : 32'd0);
            tick();
        end

        reset = 1'b0;
        bus.ws_ex = 1'b0;
        bus.ws_eret = 1'b0;
        bus.ds_allowin = 1'b1;
        set_br(1'b0, 32'h0);
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
